tlb_test_controller: RTL and testbench

Sequencer that owns the write port of the test register file (TR0–TR7) and executes the TR6/TR7 TLB test protocol. CPU `MOV TRx` writes pass through it to the register file. A write to TR6 also launches a TLB test-write or test-lookup transaction on the paging unit's test port. For lookups, the result is written back into TR7 through the same register-file write port.

---
 rtl/tlb_test_controller_if.sv | 46 ++++
 rtl/tlb_test_controller.sv | 131 +++++++++++++
 tb/tb_tlb_test_controller.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tlb_test_controller_if.sv
// tlb_test_controller_if: CPU, register-file and TLB test-port signals of the TR6/TR7 sequencer.
//   cpu_*        CPU MOV TRx write strobe/index/data in, cpu_ready back
//   tr7          current TR7 contents from the register file
//   write_*      register-file write port
//   tlb_req_*    test request to the paging unit (valid/ready handshake)
//   tlb_rsp_*    test completion pulse with lookup result
//   busy         test transaction in progress
// master = the controller, slave = its environment (CPU, register file, TLB).
interface tlb_test_controller_if;
    logic        cpu_write_enable;
    logic [2:0]  cpu_write_index;
    logic [31:0] cpu_write_data;
    logic        cpu_ready;
    logic [31:0] tr7;
    logic        write_enable;
    logic [2:0]  write_index;
    logic [31:0] write_data;
    logic        tlb_req_valid;
    logic        tlb_req_ready;
    logic        tlb_req_write;
    logic [19:0] tlb_req_linear;
    logic [6:0]  tlb_req_attr;
    logic [19:0] tlb_req_phys;
    logic [1:0]  tlb_req_way;
    logic        tlb_rsp_valid;
    logic        tlb_rsp_hit;
    logic [1:0]  tlb_rsp_way;
    logic [19:0] tlb_rsp_phys;
    logic        busy;

    modport master (
        input  cpu_write_enable, cpu_write_index, cpu_write_data, tr7,
        input  tlb_req_ready, tlb_rsp_valid, tlb_rsp_hit, tlb_rsp_way, tlb_rsp_phys,
        output cpu_ready, write_enable, write_index, write_data,
        output tlb_req_valid, tlb_req_write, tlb_req_linear, tlb_req_attr, tlb_req_phys, tlb_req_way,
        output busy
    );

    modport slave (
        output cpu_write_enable, cpu_write_index, cpu_write_data, tr7,
        output tlb_req_ready, tlb_rsp_valid, tlb_rsp_hit, tlb_rsp_way, tlb_rsp_phys,
        input  cpu_ready, write_enable, write_index, write_data,
        input  tlb_req_valid, tlb_req_write, tlb_req_linear, tlb_req_attr, tlb_req_phys, tlb_req_way,
        input  busy
    );
endinterface

// File: rtl/tlb_test_controller.sv
// tlb_test_controller: owns the test register file write port and runs the TR6/TR7 TLB test protocol.
//   clock  rising-edge clock
//   reset  asynchronous active-low reset
//   bus    tlb_test_controller_if.master: CPU write side, register-file write port, TLB test port
// CPU writes pass through in IDLE; a TR6 write launches a test write or lookup, and a lookup
// result is written back into TR7 through the same register-file port.
module tlb_test_controller (
    input  logic                 clock,
    input  logic                 reset,
    tlb_test_controller_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, UPDATE} state_t;

    state_t      state_q, state_d;
    logic [19:0] lin_q, lin_d;
    logic [6:0]  attr_q, attr_d;
    logic        lookup_q, lookup_d;
    logic [19:0] phys_q, phys_d;
    logic        h_q, h_d;
    logic [1:0]  rep_q, rep_d;
    logic [1:0]  rr_q, rr_d;
    logic        rhit_q, rhit_d;
    logic [1:0]  rway_q, rway_d;
    logic [19:0] rphys_q, rphys_d;
    logic [1:0]  req_way;
    logic        unused;

    // TR7 bits outside PPN/H/REP play no part in a test write
    assign unused  = ^{bus.tr7[11:5], bus.tr7[1:0]};
    assign req_way = h_q ? rep_q : rr_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            lin_q    <= '0;
            attr_q   <= '0;
            lookup_q <= 1'b0;
            phys_q   <= '0;
            h_q      <= 1'b0;
            rep_q    <= '0;
            rr_q     <= '0;
            rhit_q   <= 1'b0;
            rway_q   <= '0;
            rphys_q  <= '0;
        end else begin
            state_q  <= state_d;
            lin_q    <= lin_d;
            attr_q   <= attr_d;
            lookup_q <= lookup_d;
            phys_q   <= phys_d;
            h_q      <= h_d;
            rep_q    <= rep_d;
            rr_q     <= rr_d;
            rhit_q   <= rhit_d;
            rway_q   <= rway_d;
            rphys_q  <= rphys_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        lin_d              = lin_q;
        attr_d             = attr_q;
        lookup_d           = lookup_q;
        phys_d             = phys_q;
        h_d                = h_q;
        rep_d              = rep_q;
        rr_d               = rr_q;
        rhit_d             = rhit_q;
        rway_d             = rway_q;
        rphys_d            = rphys_q;
        bus.cpu_ready      = 1'b0;
        bus.write_enable   = 1'b0;
        bus.write_index    = '0;
        bus.write_data     = '0;
        bus.tlb_req_valid  = 1'b0;
        bus.tlb_req_write  = 1'b0;
        bus.tlb_req_linear = '0;
        bus.tlb_req_attr   = '0;
        bus.tlb_req_phys   = '0;
        bus.tlb_req_way    = '0;
        bus.busy           = state_q != IDLE;
        case (state_q)
            IDLE: begin
                bus.cpu_ready    = 1'b1;
                bus.write_enable = bus.cpu_write_enable;
                bus.write_index  = bus.cpu_write_index;
                bus.write_data   = bus.cpu_write_data;
                if (bus.cpu_write_enable && bus.cpu_write_index == 3'd6) begin
                    lin_d    = bus.cpu_write_data[31:12];
                    attr_d   = bus.cpu_write_data[11:5];
                    lookup_d = bus.cpu_write_data[0];
                    phys_d   = bus.tr7[31:12];
                    h_d      = bus.tr7[4];
                    rep_d    = bus.tr7[3:2];
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                bus.tlb_req_valid  = 1'b1;
                bus.tlb_req_write  = !lookup_q;
                bus.tlb_req_linear = lin_q;
                bus.tlb_req_attr   = attr_q;
                bus.tlb_req_phys   = lookup_q ? 20'h0 : phys_q;
                bus.tlb_req_way    = lookup_q ? 2'd0 : req_way;
                if (bus.tlb_req_ready) begin
                    state_d = WAIT_RSP;
                    // round-robin only advances when it actually picked the way
                    if (!lookup_q && !h_q) rr_d = rr_q + 2'd1;
                end
            end
            WAIT_RSP: begin
                if (bus.tlb_rsp_valid) begin
                    state_d = lookup_q ? UPDATE : IDLE;
                    if (lookup_q) begin
                        rhit_d  = bus.tlb_rsp_hit;
                        rway_d  = bus.tlb_rsp_way;
                        rphys_d = bus.tlb_rsp_phys;
                    end
                end
            end
            UPDATE: begin
                bus.write_enable = 1'b1;
                bus.write_index  = 3'd7;
                bus.write_data   = rhit_q ? {rphys_q, 7'b0, 1'b1, rway_q, 2'b00} : 32'h0;
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_tlb_test_controller.sv
// tb_tlb_test_controller: scoreboard bench for the TR6/TR7 test sequencer with a register-file model.
module tb_tlb_test_controller;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] rf [8] = '{default: 32'h0};
    logic [1:0]  m_rr = 2'd0;
    logic [34:0] wr_q [$];
    logic [49:0] req_q [$];
    logic [34:0] exp_wr;
    logic [49:0] exp_req;
    logic [49:0] last_req = '0;
    int          stall_cycles = 0;

    tlb_test_controller_if bus();

    tlb_test_controller dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    assign bus.tr7 = rf[7];

    always @(posedge clock) if (bus.write_enable) rf[bus.write_index] <= bus.write_data;

    always @(negedge clock) begin
        if (bus.write_enable) begin
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL rf_write: got idx=%0d data=%h, required no write", bus.write_index, bus.write_data);
            end else begin
                exp_wr = wr_q.pop_front();
                if ({bus.write_index, bus.write_data} !== exp_wr) begin
                    errors++;
                    $display("FAIL rf_write: got idx=%0d data=%h, required idx=%0d data=%h",
                             bus.write_index, bus.write_data, exp_wr[34:32], exp_wr[31:0]);
                end
            end
        end
    end

    always @(negedge clock) begin
        if (bus.tlb_req_valid && bus.tlb_req_ready) begin
            last_req = {bus.tlb_req_write, bus.tlb_req_linear, bus.tlb_req_attr, bus.tlb_req_phys, bus.tlb_req_way};
            checks++;
            if (req_q.size() == 0) begin
                errors++;
                $display("FAIL tlb_req: got %h, required no request", last_req);
            end else begin
                exp_req = req_q.pop_front();
                if (last_req !== exp_req) begin
                    errors++;
                    $display("FAIL tlb_req: got %h, required %h", last_req, exp_req);
                end
            end
        end
    end

    task automatic cpu_write(input logic [2:0] idx, input logic [31:0] d);
        int n;
        n = 0;
        wr_q.push_back({idx, d});
        bus.cpu_write_enable = 1'b1;
        bus.cpu_write_index  = idx;
        bus.cpu_write_data   = d;
        @(negedge clock);
        while (!bus.cpu_ready && n < 100) begin
            n++;
            @(negedge clock);
        end
        stall_cycles = n;
        checks++;
        if (!bus.cpu_ready) begin
            errors++;
            $display("FAIL cpu_accept: cpu_ready=%b after %0d cycles, required 1", bus.cpu_ready, n);
        end
        @(posedge clock); #1;
        bus.cpu_write_enable = 1'b0;
    endtask

    task automatic tlb_serve(input int delay, input logic hit, input logic [1:0] way, input logic [19:0] phys);
        int n;
        logic [49:0] snap;
        n = 0;
        bus.tlb_req_ready = (delay == 0);
        @(negedge clock);
        while (!bus.tlb_req_valid && n < 20) begin
            n++;
            @(negedge clock);
        end
        checks++;
        if (!bus.tlb_req_valid) begin
            errors++;
            $display("FAIL tlb_req_valid: got 0 after %0d cycles, required 1", n);
            bus.tlb_req_ready = 1'b0;
            return;
        end
        snap = {bus.tlb_req_write, bus.tlb_req_linear, bus.tlb_req_attr, bus.tlb_req_phys, bus.tlb_req_way};
        for (int i = 0; i < delay; i++) begin
            checks++;
            if (!bus.tlb_req_valid ||
                {bus.tlb_req_write, bus.tlb_req_linear, bus.tlb_req_attr, bus.tlb_req_phys, bus.tlb_req_way} !== snap) begin
                errors++;
                $display("FAIL req_stable: cycle %0d valid=%b fields=%h, required valid=1 fields=%h", i, bus.tlb_req_valid,
                         {bus.tlb_req_write, bus.tlb_req_linear, bus.tlb_req_attr, bus.tlb_req_phys, bus.tlb_req_way}, snap);
            end
            @(posedge clock); #1;
            if (i == delay - 1) bus.tlb_req_ready = 1'b1;
            @(negedge clock);
        end
        @(posedge clock); #1;
        bus.tlb_req_ready = 1'b0;
        bus.tlb_rsp_valid = 1'b1;
        bus.tlb_rsp_hit   = hit;
        bus.tlb_rsp_way   = way;
        bus.tlb_rsp_phys  = phys;
        @(posedge clock); #1;
        bus.tlb_rsp_valid = 1'b0;
        bus.tlb_rsp_hit   = 1'b0;
        bus.tlb_rsp_way   = 2'd0;
        bus.tlb_rsp_phys  = 20'h0;
    endtask

    task automatic tr6_cmd(input logic [31:0] cmd, input int delay, input logic hit, input logic [1:0] way,
                           input logic [19:0] phys, input logic stall, input logic [31:0] stall_data);
        logic       wr;
        logic       h;
        logic [1:0] w;
        wr = ~cmd[0];
        h  = rf[7][4];
        w  = h ? rf[7][3:2] : m_rr;
        req_q.push_back({wr, cmd[31:12], cmd[11:5], wr ? rf[7][31:12] : 20'h0, wr ? w : 2'd0});
        if (wr && !h) m_rr = m_rr + 2'd1;
        cpu_write(3'd6, cmd);
        if (!wr) wr_q.push_back({3'd7, hit ? {phys, 7'b0, 1'b1, way, 2'b00} : 32'h0});
        if (stall) begin
            fork
                cpu_write(3'd7, stall_data);
                tlb_serve(delay, hit, way, phys);
            join
        end else begin
            tlb_serve(delay, hit, way, phys);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({bus.write_enable, bus.tlb_req_valid, bus.busy, bus.tlb_req_write, bus.tlb_req_linear,
             bus.tlb_req_attr, bus.tlb_req_phys, bus.tlb_req_way, bus.cpu_ready} !== {52'h0, 1'b1}) begin
            errors++;
            $display("FAIL reset_outputs: we=%b valid=%b busy=%b req=%h ready=%b, required all 0 and ready=1",
                     bus.write_enable, bus.tlb_req_valid, bus.busy,
                     {bus.tlb_req_write, bus.tlb_req_linear, bus.tlb_req_attr, bus.tlb_req_phys, bus.tlb_req_way}, bus.cpu_ready);
        end
        @(posedge clock); #1;
        reset = 1'b1;
    endtask

    task automatic test_pass_through();
        wr_q.push_back({3'd3, 32'h1234_5678});
        bus.cpu_write_enable = 1'b1;
        bus.cpu_write_index  = 3'd3;
        bus.cpu_write_data   = 32'h1234_5678;
        @(negedge clock);
        checks++;
        if ({bus.write_enable, bus.write_index, bus.write_data, bus.busy, bus.cpu_ready} !== {1'b1, 3'd3, 32'h1234_5678, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL pass_through: we=%b idx=%0d data=%h busy=%b ready=%b, required 1/3/12345678/0/1",
                     bus.write_enable, bus.write_index, bus.write_data, bus.busy, bus.cpu_ready);
        end
        @(posedge clock); #1;
        bus.cpu_write_enable = 1'b0;
        checks++;
        if (rf[3] !== 32'h1234_5678) begin
            errors++;
            $display("FAIL tr3_value: got %h, required 12345678", rf[3]);
        end
    endtask

    task automatic test_write_h0();
        cpu_write(3'd7, 32'hABCDE000);
        tr6_cmd(32'h12345E00, 0, 1'b0, 2'd0, 20'h0, 1'b0, 32'h0);
        @(negedge clock);
        checks++;
        if ({bus.busy, bus.cpu_ready} !== 2'b01) begin
            errors++;
            $display("FAIL write_idle_cycle3: busy=%b ready=%b, required busy=0 ready=1", bus.busy, bus.cpu_ready);
        end
        checks++;
        if (last_req !== {1'b1, 20'h12345, 7'b1110000, 20'hABCDE, 2'd0}) begin
            errors++;
            $display("FAIL write_h0_first: got %h, required way 0 request %h", last_req,
                     {1'b1, 20'h12345, 7'b1110000, 20'hABCDE, 2'd0});
        end
        @(posedge clock); #1;
        tr6_cmd(32'h12345E00, 0, 1'b0, 2'd0, 20'h0, 1'b0, 32'h0);
        checks++;
        if (last_req[1:0] !== 2'd1) begin
            errors++;
            $display("FAIL write_h0_second_way: got %0d, required 1", last_req[1:0]);
        end
    endtask

    task automatic test_write_h1();
        cpu_write(3'd7, 32'h0000_001C);
        tr6_cmd(32'h00042E00, 0, 1'b0, 2'd0, 20'h0, 1'b0, 32'h0);
        checks++;
        if (last_req[1:0] !== 2'd3) begin
            errors++;
            $display("FAIL write_h1_way: got %0d, required 3", last_req[1:0]);
        end
        cpu_write(3'd7, 32'h13579000);
        tr6_cmd(32'h00043000, 0, 1'b0, 2'd0, 20'h0, 1'b0, 32'h0);
        checks++;
        if (last_req[1:0] !== 2'd2) begin
            errors++;
            $display("FAIL rr_after_h1: got way %0d, required 2", last_req[1:0]);
        end
    endtask

    task automatic test_lookup_hit();
        tr6_cmd(32'h12345801, 0, 1'b1, 2'd2, 20'h55555, 1'b0, 32'h0);
        checks++;
        if (last_req !== {1'b0, 20'h12345, 7'b1000000, 20'h0, 2'd0}) begin
            errors++;
            $display("FAIL lookup_req: got %h, required %h", last_req, {1'b0, 20'h12345, 7'b1000000, 20'h0, 2'd0});
        end
        @(negedge clock);
        checks++;
        if ({bus.cpu_ready, bus.busy, bus.write_enable, bus.write_index} !== {1'b0, 1'b1, 1'b1, 3'd7}) begin
            errors++;
            $display("FAIL update_cycle: ready=%b busy=%b we=%b idx=%0d, required 0/1/1/7",
                     bus.cpu_ready, bus.busy, bus.write_enable, bus.write_index);
        end
        @(posedge clock); #1;
        checks++;
        if (rf[7] !== 32'h55555018 || bus.cpu_ready !== 1'b1) begin
            errors++;
            $display("FAIL lookup_hit_tr7: tr7=%h ready=%b, required 55555018 ready=1", rf[7], bus.cpu_ready);
        end
    endtask

    task automatic test_back_to_back_stall();
        tr6_cmd(32'h0BEEF001, 5, 1'b0, 2'd3, 20'hFFFFF, 1'b1, 32'hCAFEF00D);
        checks++;
        if (stall_cycles != 8) begin
            errors++;
            $display("FAIL stall_cycles: got %0d, required 8", stall_cycles);
        end
        checks++;
        if (rf[7] !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL stalled_tr7: got %h, required cafef00d", rf[7]);
        end
    endtask

    task automatic test_reset_mid();
        req_q.push_back({1'b0, 20'h00777, 7'b0, 20'h0, 2'd0});
        bus.tlb_req_ready = 1'b1;
        cpu_write(3'd6, 32'h00777001);
        @(posedge clock); #1;
        bus.tlb_req_ready = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL wait_rsp_busy: got %b, required 1", bus.busy);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.tlb_req_valid, bus.write_enable, bus.cpu_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL async_reset: busy=%b valid=%b we=%b ready=%b, required 0/0/0/1",
                     bus.busy, bus.tlb_req_valid, bus.write_enable, bus.cpu_ready);
        end
        @(posedge clock); #1;
        reset = 1'b1;
        m_rr = 2'd0;
        bus.tlb_rsp_valid = 1'b1;
        bus.tlb_rsp_hit   = 1'b1;
        bus.tlb_rsp_way   = 2'd1;
        bus.tlb_rsp_phys  = 20'h12345;
        @(posedge clock); #1;
        bus.tlb_rsp_valid = 1'b0;
        repeat (3) begin
            @(negedge clock);
            checks++;
            if ({bus.write_enable, bus.busy} !== 2'b00) begin
                errors++;
                $display("FAIL stray_rsp: we=%b busy=%b, required 0/0", bus.write_enable, bus.busy);
            end
        end
        @(posedge clock); #1;
        checks++;
        if (rf[7] !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL tr7_after_reset: got %h, required cafef00d", rf[7]);
        end
        cpu_write(3'd7, 32'h22222000);
        tr6_cmd(32'h33333E00, 0, 1'b0, 2'd0, 20'h0, 1'b0, 32'h0);
        checks++;
        if (last_req[1:0] !== 2'd0) begin
            errors++;
            $display("FAIL rr_reset: got way %0d, required 0", last_req[1:0]);
        end
    endtask

    initial begin
        bus.cpu_write_enable = 1'b0;
        bus.cpu_write_index  = 3'd0;
        bus.cpu_write_data   = 32'h0;
        bus.tlb_req_ready    = 1'b0;
        bus.tlb_rsp_valid    = 1'b0;
        bus.tlb_rsp_hit      = 1'b0;
        bus.tlb_rsp_way      = 2'd0;
        bus.tlb_rsp_phys     = 20'h0;
        test_reset();
        test_pass_through();
        test_write_h0();
        test_write_h1();
        test_lookup_hit();
        test_back_to_back_stall();
        test_reset_mid();
        repeat (2) @(posedge clock);
        checks++;
        if (wr_q.size() != 0) begin
            errors++;
            $display("FAIL rf_write_drain: %0d writes outstanding, required 0", wr_q.size());
        end
        checks++;
        if (req_q.size() != 0) begin
            errors++;
            $display("FAIL tlb_req_drain: %0d requests outstanding, required 0", req_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
